// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and taken-branch flush sequencing for the
// ID/EX and IF/ID pipeline latches, plus saturating stall/flush event counters.
//
// Control outputs are combinational so the latches react in the same cycle.
// The pipeline has no valid/ready handshake: every control takes effect on the
// posedge where it is high, and an enable held low freezes its stage.
// fsm_state exposes the current FSM state (0 = RUN, 1 = FLUSH) for debug.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  output logic             stop,
  output logic             branch_reset,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             fsm_state
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Value loaded into flush_left when a taken branch starts a flush; the
  // redirect cycle itself counts as the first flush cycle.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam bit         MULTI      = (FLUSH_CYCLES > 1);

  state_t     state, next_state;
  logic [3:0] flush_left, next_flush_left;
  logic       lu_hit;
  logic       stall_inc;
  logic       flush_inc;

  // Load in EX writes a register the ID instruction reads; x0 never hazards.
  assign lu_hit = ex_MemRead && (ex_rd != 5'd0) &&
                  ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  assign fsm_state = state;

  // Next-state, flush countdown and same-cycle latch controls.
  always_comb begin
    next_state      = state;
    next_flush_left = flush_left;
    stop            = 1'b0;
    branch_reset    = 1'b0;
    ifid_flush      = 1'b0;
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            branch_reset = 1'b1;
            ifid_flush   = 1'b1;
            flush_inc    = 1'b1;
            if (MULTI) begin
              next_state      = FLUSH;
              next_flush_left = FLUSH_INIT;
            end
          end else if (lu_hit) begin
            stop       = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_inc  = 1'b1;
          end
        end
        FLUSH: begin
          // The ID instruction is wrong-path here, so load-use is ignored.
          branch_reset = 1'b1;
          ifid_flush   = 1'b1;
          if (branch_taken) begin
            flush_inc = 1'b1;
            if (MULTI) begin
              next_flush_left = FLUSH_INIT;
            end else begin
              next_state      = RUN;
              next_flush_left = 4'd0;
            end
          end else if (flush_left <= 4'd1) begin
            next_state      = RUN;
            next_flush_left = 4'd0;
          end else begin
            next_flush_left = flush_left - 4'd1;
          end
        end
        default: begin
          next_state      = RUN;
          next_flush_left = 4'd0;
        end
      endcase
    end
  end

  // FSM state and flush countdown registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      flush_left <= 4'd0;
    end else begin
      state      <= next_state;
      flush_left <= next_flush_left;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl. Three instances share the
// stimulus: default parameters, FLUSH_CYCLES=4, and CNT_W=4.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_MemRead, branch_taken;

  logic        a_stop, a_br, a_pcw, a_ifw, a_iff, a_st;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_stop, b_br, b_pcw, b_ifw, b_iff, b_st;
  logic [15:0] b_scnt, b_fcnt;
  logic        c_stop, c_br, c_pcw, c_ifw, c_iff, c_st;
  logic [3:0]  c_scnt, c_fcnt;

  hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .stop(a_stop), .branch_reset(a_br),
    .pc_write(a_pcw), .ifid_write(a_ifw), .ifid_flush(a_iff),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt), .fsm_state(a_st));

  hazard_ctrl #(.FLUSH_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .stop(b_stop), .branch_reset(b_br),
    .pc_write(b_pcw), .ifid_write(b_ifw), .ifid_flush(b_iff),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt), .fsm_state(b_st));

  hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .stop(c_stop), .branch_reset(c_br),
    .pc_write(c_pcw), .ifid_write(c_ifw), .ifid_flush(c_iff),
    .stall_cnt(c_scnt), .flush_cnt(c_fcnt), .fsm_state(c_st));

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1ns after posedge; outputs are sampled on negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                       input logic mr, input logic [4:0] rd, input logic br);
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_uses_rs2  = uses;
    ex_MemRead   = mr;
    ex_rd        = rd;
    branch_taken = br;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle();
    tick();

    // Reset forces outputs even with hazard and branch present.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    sample();
    check("rst_stop", a_stop, 0);
    check("rst_br", a_br, 0);
    check("rst_iff", a_iff, 0);
    check("rst_pcw", a_pcw, 1);
    check("rst_ifw", a_ifw, 1);
    tick();
    reset = 1'b0;
    idle();
    sample();
    check("rst_state", a_st, 0);
    check("rst_scnt", a_scnt, 0);
    check("rst_fcnt", a_fcnt, 0);

    // Load-use on rs1: one bubble.
    tick();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    sample();
    check("lu1_stop", a_stop, 1);
    check("lu1_pcw", a_pcw, 0);
    check("lu1_ifw", a_ifw, 0);
    check("lu1_br", a_br, 0);
    tick();
    drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    sample();
    check("lu1_after_stop", a_stop, 0);
    check("lu1_after_pcw", a_pcw, 1);
    check("lu1_scnt", a_scnt, 1);

    // rs2 only counts when id_uses_rs2.
    tick();
    drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0);
    sample();
    check("rs2_unused_stop", a_stop, 0);
    tick();
    drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
    sample();
    check("rs2_used_stop", a_stop, 1);
    tick();
    // x0 never stalls.
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    sample();
    check("x0_stop", a_stop, 0);
    check("x0_pcw", a_pcw, 1);
    tick();
    idle();
    sample();
    check("rs2_scnt", a_scnt, 2);

    // Branch flush: 2 cycles on default, 4 cycles on u_dut4.
    do_reset();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int t = 0; t < 5; t++) begin
      sample();
      check($sformatf("brf_br_t%0d", t), a_br, (t < 2) ? 1 : 0);
      check($sformatf("brf_iff_t%0d", t), a_iff, (t < 2) ? 1 : 0);
      check($sformatf("brf_pcw_t%0d", t), a_pcw, 1);
      check($sformatf("brf_stop_t%0d", t), a_stop, 0);
      check($sformatf("brf4_br_t%0d", t), b_br, (t < 4) ? 1 : 0);
      tick();
      idle();
    end
    sample();
    check("brf_fcnt", a_fcnt, 1);
    check("brf4_fcnt", b_fcnt, 1);
    check("brf_state", a_st, 0);

    // Collision, restart, and lu_hit ignored in FLUSH.
    tick();
    do_reset();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    sample();
    check("col_stop", a_stop, 0);
    check("col_br", a_br, 1);
    tick();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    sample();
    check("restart_br", a_br, 1);
    check("restart_stop", a_stop, 0);
    tick();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    sample();
    check("flush_lu_br", a_br, 1);
    check("flush_lu_stop", a_stop, 0);
    check("flush_lu_pcw", a_pcw, 1);
    tick();
    idle();
    sample();
    check("restart_end_br", a_br, 0);
    check("col_scnt", a_scnt, 0);
    check("col_fcnt", a_fcnt, 2);

    // Reset mid-flush on FLUSH_CYCLES=4.
    tick();
    do_reset();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
    sample();
    check("rmf_br_T", b_br, 1);
    tick();
    reset = 1'b1;
    idle();
    sample();
    check("rmf_br_T1", b_br, 0);
    check("rmf_pcw_T1", b_pcw, 1);
    tick();
    reset = 1'b0;
    drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    sample();
    check("rmf_fcnt_T2", b_fcnt, 0);
    check("rmf_scnt_T2", b_scnt, 0);
    check("rmf_br_T2", b_br, 0);
    check("rmf_stop_T2", b_stop, 1);
    check("rmf_state_T2", b_st, 0);

    // Saturation: 17 load-use cycles.
    tick();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(5'(i % 31 + 1), 5'd0, 1'b0, 1'b1, 5'(i % 31 + 1), 1'b0);
      tick();
    end
    idle();
    sample();
    check("sat_scnt4", c_scnt, 15);
    check("sat_scnt16", a_scnt, 17);
    tick();
    sample();
    check("sat_hold", c_scnt, 15);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
